xinput_capture: RTL and testbench

//  Memory-mapped input peripheral: the read-side counterpart of the display writer path.
//  - Synchronises and debounces the push buttons and slide switches.
//  - Latches button presses as sticky flags and counts them.
//  - The controller reads all of this through the internal address decoder (data_to_rd mux).

---
 rtl/xinput_capture_pkg.sv | 20 ++
 rtl/xinput_capture_xdebounce.sv | 51 +++++
 rtl/xinput_capture.sv | 126 ++++++++++++
 tb/tb_xinput_capture.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xinput_capture_pkg.sv
// -----------------------------------------------------------------------------
// xinput_capture_pkg
// Shared definitions for the input-capture peripheral: register offsets seen
// through the address decoder, the IRQ mask bit position in the BTN register,
// the decoder base address and the press-count type.
// Optional feature macro used by the peripheral: XINPUT_IRQ_EN.
// -----------------------------------------------------------------------------
package xinput_capture_pkg;

    localparam logic [1:0]  XIN_FLAGS        = 2'd0;
    localparam logic [1:0]  XIN_SW           = 2'd1;
    localparam logic [1:0]  XIN_BTN          = 2'd2;
    localparam logic [1:0]  XIN_COUNT        = 2'd3;

    localparam int          XIN_IRQ_MASK_BIT = 31;
    localparam logic [31:0] XIN_BASE         = 32'h0000_0040;

    typedef logic [7:0] press_count_t;

endpackage

// File: rtl/xinput_capture_xdebounce.sv
// -----------------------------------------------------------------------------
// xdebounce
// Two-flop synchroniser followed by a debounce counter for one raw input.
// A new level is accepted only after the synchronised value has differed from
// the current stable level for DEB_LIMIT consecutive cycles; any cycle where
// they agree restarts the window.
// Ports:
//   clk     system clock
//   rst     asynchronous reset, active-low
//   din     raw input, asynchronous to clk
//   stable  debounced level (0 after reset)
// -----------------------------------------------------------------------------
module xdebounce #(
    parameter int unsigned DEB_LIMIT = 500000,
    parameter int          DEB_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_LIMIT - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            stable  <= 1'b0;
        end else begin
            // synchroniser stage boundary
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            // debounce stage boundary
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/xinput_capture.sv
// -----------------------------------------------------------------------------
// xinput_capture
// Memory-mapped input peripheral. Debounces push buttons and slide switches,
// latches button presses as sticky W1C flags and counts them (mod 256).
// Optional feature: define XINPUT_IRQ_EN to add the irq output and the IRQ
// mask bit (bit 31 of the BTN register).
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-low
//   btn       raw push buttons (bit0=Btn2, bit1=Btn3)
//   sw        raw slide switches
//   sel       peripheral select from the address decoder
//   we        write enable, qualified by sel
//   addr      register offset: 0 FLAGS, 1 SW, 2 BTN, 3 COUNT
//   data_in   write data
//   data_out  read data, combinational from addr, 0 when sel=0
//   irq       registered press-pending interrupt (XINPUT_IRQ_EN only)
// -----------------------------------------------------------------------------
module xinput_capture
    import xinput_capture_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          N_BTN     = 2,
    parameter int          N_SW      = 8,
    parameter int unsigned DEB_LIMIT = 500000,
    parameter int          DEB_W     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn,
    input  logic [N_SW-1:0]   sw,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
`ifdef XINPUT_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_stable_d;
    logic [N_BTN-1:0] press;
    logic [N_SW-1:0]  sw_stable;
    logic [N_BTN-1:0] flags;
    logic [N_BTN-1:0] flags_clr;
    press_count_t     count;
    logic             wr;
    logic             unused_data;

    function automatic press_count_t n_events(input logic [N_BTN-1:0] p);
        press_count_t n;
        n = '0;
        for (int i = 0; i < N_BTN; i++) begin
            n = n + press_count_t'(p[i]);
        end
        return n;
    endfunction

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        xdebounce #(.DEB_LIMIT(DEB_LIMIT), .DEB_W(DEB_W)) u_deb (
            .clk(clk), .rst(rst), .din(btn[i]), .stable(btn_stable[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        xdebounce #(.DEB_LIMIT(DEB_LIMIT), .DEB_W(DEB_W)) u_deb (
            .clk(clk), .rst(rst), .din(sw[i]), .stable(sw_stable[i])
        );
    end

    assign wr          = sel && we;
    // Only the rising edge of the debounced level is a press; releases are ignored.
    assign press       = btn_stable & ~btn_stable_d;
    assign flags_clr   = (wr && addr == XIN_FLAGS) ? data_in[N_BTN-1:0] : '0;
    assign unused_data = ^data_in;

    // A press in the same cycle as a W1C/clear write wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_stable_d <= '0;
            flags        <= '0;
            count        <= '0;
        end else begin
            btn_stable_d <= btn_stable;
            flags        <= (flags & ~flags_clr) | press;
            count        <= ((wr && addr == XIN_COUNT) ? press_count_t'(0) : count) + n_events(press);
        end
    end

`ifdef XINPUT_IRQ_EN
    logic irq_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_mask <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr && addr == XIN_BTN) begin
                irq_mask <= data_in[XIN_IRQ_MASK_BIT];
            end
            irq <= (|flags) & irq_mask;
        end
    end
`endif

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (addr)
                XIN_FLAGS: data_out[N_BTN-1:0] = flags;
                XIN_SW:    data_out[N_SW-1:0]  = sw_stable;
                XIN_BTN: begin
                    data_out[N_BTN-1:0] = btn_stable;
`ifdef XINPUT_IRQ_EN
                    data_out[XIN_IRQ_MASK_BIT] = irq_mask;
`endif
                end
                default:   data_out[7:0] = count;
            endcase
        end
    end

endmodule

// File: tb/tb_xinput_capture.sv
// -----------------------------------------------------------------------------
// tb_xinput_capture
// Self-checking bench for xinput_capture with DEB_LIMIT=4. A reference model
// describes debouncing as "a new level is taken once DEB_LIMIT consecutive
// samples, seen two cycles late, all differ from the current level", and
// tracks flags, count, mask and irq from register-level rules.
// -----------------------------------------------------------------------------
module tb_xinput_capture;

    localparam int D  = 4;
    localparam int NI = 10;

    logic        clk;
    logic        rst;
    logic [1:0]  btn;
    logic [7:0]  sw;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
`ifdef XINPUT_IRQ_EN
    logic        irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    xinput_capture #(.DATA_W(32), .N_BTN(2), .N_SW(8), .DEB_LIMIT(D), .DEB_W(4)) dut (
        .clk(clk), .rst(rst), .btn(btn), .sw(sw), .sel(sel), .we(we),
        .addr(addr), .data_in(data_in), .data_out(data_out)
`ifdef XINPUT_IRQ_EN
        , .irq(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [D+1:0][NI-1:0] smp;
        logic [NI-1:0]        stable;
        logic [1:0]           pend;
        logic [1:0]           flags;
        logic [7:0]           count;
        logic                 mask;
        logic                 irq;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, logic w, logic [1:0] a,
                                           logic [31:0] d, logic [NI-1:0] raw);
        mstate_t    n;
        logic [1:0] clr;
        logic       ok;
        n       = s;
        n.irq   = (|s.flags) & s.mask;
        clr     = (w && a == 2'd0) ? d[1:0] : 2'b00;
        n.flags = (s.flags & ~clr) | s.pend;
        n.count = ((w && a == 2'd3) ? 8'd0 : s.count) + 8'(s.pend[0]) + 8'(s.pend[1]);
        if (w && a == 2'd2) n.mask = d[31];
        n.smp = {s.smp[D:0], raw};
        for (int b = 0; b < NI; b++) begin
            ok = 1'b1;
            for (int k = 2; k <= D + 1; k++) begin
                if (n.smp[k][b] == s.stable[b]) ok = 1'b0;
            end
            if (ok) n.stable[b] = ~s.stable[b];
        end
        n.pend = n.stable[1:0] & ~s.stable[1:0];
        return n;
    endfunction

    function automatic logic [31:0] exp_reg(mstate_t s, logic [1:0] a);
        case (a)
            2'd0:    return {30'b0, s.flags};
            2'd1:    return {24'b0, s.stable[9:2]};
`ifdef XINPUT_IRQ_EN
            2'd2:    return {s.mask, 29'b0, s.stable[1:0]};
`else
            2'd2:    return {30'b0, s.stable[1:0]};
`endif
            default: return {24'b0, s.count};
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else      m <= model_next(m, sel && we, addr, data_in, {sw, btn});
    end

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        v = data_out;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel     = 1'b1;
        we      = 1'b1;
        addr    = a;
        data_in = d;
        @(negedge clk);
        we      = 1'b0;
        data_in = '0;
    endtask

    task automatic press0();
        btn[0] = 1'b1;
        repeat (7) @(negedge clk);
        btn[0] = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0; btn = 2'b11; sw = 8'hA5; sel = 1'b1; we = 1'b0; addr = 2'd0; data_in = '0;
        repeat (3) @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            n_tests++;
            if (v !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 0", a, v); end
        end
        rst = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            rd(2'd1, v);
            n_tests++;
            if (v !== ((c >= 6) ? 32'hA5 : 32'h0)) begin
                n_fail++; $display("FAIL reset_sw_cycle%0d: got %h want %h", c, v, (c >= 6) ? 32'hA5 : 32'h0);
            end
        end
        rd(2'd0, v);
        n_tests++;
        if (v !== 32'h3) begin n_fail++; $display("FAIL reset_held_flags: got %h want 3", v); end
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'h2) begin n_fail++; $display("FAIL reset_held_count: got %h want 2", v); end
        sel = 1'b0;
        #1;
        n_tests++;
        if (data_out !== 32'h0) begin n_fail++; $display("FAIL sel_low: got %h want 0", data_out); end
        sel = 1'b1;
        btn = 2'b00;
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, v);
        n_tests++;
        if (v !== 32'hA5) begin n_fail++; $display("FAIL sw_readonly: got %h want a5", v); end
        repeat (8) @(negedge clk);
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'h2) begin n_fail++; $display("FAIL release_count: got %h want 2", v); end
        wr(2'd0, 32'h3);
        wr(2'd3, 32'h0);
        rd(2'd0, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL w1c_all: got %h want 0", v); end
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL count_clear: got %h want 0", v); end
    endtask

    task automatic test_bounce();
        logic [31:0] v;
        for (int k = 0; k < 4; k++) begin
            btn[0] = ~btn[0];
            repeat (2) @(negedge clk);
        end
        btn[0] = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            rd(2'd2, v);
            n_tests++;
            if (v !== ((c >= 6) ? 32'h1 : 32'h0)) begin
                n_fail++; $display("FAIL bounce_btn_cycle%0d: got %h want %0d", c, v, (c >= 6));
            end
        end
        repeat (2) @(negedge clk);
        rd(2'd0, v);
        n_tests++;
        if (v !== 32'h1) begin n_fail++; $display("FAIL bounce_flags: got %h want 1", v); end
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'h1) begin n_fail++; $display("FAIL bounce_count: got %h want 1", v); end
        btn[0] = 1'b0;
        repeat (10) @(negedge clk);
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'h1) begin n_fail++; $display("FAIL bounce_release_count: got %h want 1", v); end
        wr(2'd0, 32'h1);
    endtask

    task automatic test_hold_release();
        logic [31:0] v;
        wr(2'd3, 32'h0);
        btn[1] = 1'b1;
        repeat (100) @(negedge clk);
        rd(2'd2, v);
        n_tests++;
        if (v[1:0] !== 2'b10) begin n_fail++; $display("FAIL hold_btn: got %h want 2", v); end
        btn[1] = 1'b0;
        repeat (10) @(negedge clk);
        rd(2'd0, v);
        n_tests++;
        if (v !== 32'h2) begin n_fail++; $display("FAIL hold_flags: got %h want 2", v); end
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'h1) begin n_fail++; $display("FAIL hold_count: got %h want 1", v); end
        rd(2'd2, v);
        n_tests++;
        if (v[1:0] !== 2'b00) begin n_fail++; $display("FAIL release_btn: got %h want 0", v); end
        wr(2'd0, 32'h2);
    endtask

    task automatic test_w1c_race();
        logic [31:0] v;
        btn[0] = 1'b1;
        repeat (6) @(negedge clk);
        wr(2'd0, 32'h1);
        rd(2'd0, v);
        n_tests++;
        if (v !== 32'h1) begin n_fail++; $display("FAIL w1c_race: got %h want 1", v); end
        wr(2'd0, 32'h1);
        rd(2'd0, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL w1c_after: got %h want 0", v); end
        btn[0] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        wr(2'd3, 32'h0);
        for (int i = 0; i < 256; i++) press0();
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL wrap_256: got %h want 0", v); end
        for (int i = 0; i < 255; i++) press0();
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'hFF) begin n_fail++; $display("FAIL count_ff: got %h want ff", v); end
        btn = 2'b11;
        repeat (8) @(negedge clk);
        btn = 2'b00;
        repeat (7) @(negedge clk);
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'h1) begin n_fail++; $display("FAIL wrap_double: got %h want 1", v); end
        btn = 2'b11;
        repeat (6) @(negedge clk);
        wr(2'd3, 32'h5A);
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'h2) begin n_fail++; $display("FAIL clear_race_count: got %h want 2", v); end
        btn = 2'b00;
        repeat (7) @(negedge clk);
        wr(2'd3, 32'h5A);
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL count_write_clear: got %h want 0", v); end
        wr(2'd0, 32'h3);
    endtask

`ifdef XINPUT_IRQ_EN
    task automatic test_irq();
        logic [31:0] v;
        btn[0] = 1'b1;
        repeat (8) @(negedge clk);
        btn[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", irq); end
        end
        wr(2'd2, 32'h8000_0000);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_mask_delay: got %b want 0", irq); end
        @(negedge clk);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
        rd(2'd2, v);
        n_tests++;
        if (v[31] !== 1'b1) begin n_fail++; $display("FAIL irq_mask_read: got %h want bit31 set", v); end
        wr(2'd0, 32'h3);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_clear_delay: got %b want 1", irq); end
        @(negedge clk);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b want 0", irq); end
        wr(2'd2, 32'h0);
        repeat (8) @(negedge clk);
    endtask
`endif

    task automatic test_mid_reset();
        logic [31:0] v;
        press0();
        btn[0] = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        rd(2'd3, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_count: got %h want 0", v); end
        rd(2'd0, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_flags: got %h want 0", v); end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            rd(2'd2, v);
            n_tests++;
            if (v !== ((c >= 6) ? 32'h1 : 32'h0)) begin
                n_fail++; $display("FAIL midrst_btn_cycle%0d: got %h want %0d", c, v, (c >= 6));
            end
            rd(2'd0, v);
            n_tests++;
            if (v !== ((c >= 7) ? 32'h1 : 32'h0)) begin
                n_fail++; $display("FAIL midrst_flags_cycle%0d: got %h want %0d", c, v, (c >= 7));
            end
        end
        btn[0] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int c = 0; c < 1500; c++) begin
            for (int a = 0; a < 4; a++) begin
                rd(2'(a), v);
                n_tests++;
                if (v !== exp_reg(m, 2'(a))) begin
                    n_fail++; $display("FAIL random_reg%0d cycle %0d: got %h want %h", a, c, v, exp_reg(m, 2'(a)));
                end
            end
`ifdef XINPUT_IRQ_EN
            n_tests++;
            if (irq !== m.irq) begin n_fail++; $display("FAIL random_irq cycle %0d: got %b want %b", c, irq, m.irq); end
`endif
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
            end
            if ($urandom_range(0, 9) == 0) sw = sw ^ (8'd1 << $urandom_range(0, 7));
            if ($urandom_range(0, 11) == 0) begin
                we      = 1'b1;
                addr    = 2'($urandom_range(0, 3));
                data_in = $urandom;
            end
            @(negedge clk);
            we      = 1'b0;
            data_in = '0;
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_hold_release();
        test_w1c_race();
        test_wrap();
`ifdef XINPUT_IRQ_EN
        test_irq();
`endif
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
